plru_array: RTL and testbench
=============================

# plru_array

Parametrised multi-set tree pseudo-LRU replacement array for the set-associative caches. It holds one binary pLRU tree plus per-way valid bits for every set, and reports the victim way for the addressed set, preferring invalid ways over the tree choice. A sequenced flush engine clears every set over SETS cycles, which allows cache invalidation without a wide reset fan-out.

## Interface
- WAYS, 8, associativity; power of two, ≥2. WAY_W = $clog2(WAYS).
- SETS, 8, number of sets; power of two, ≥2. IDX_W = $clog2(SETS).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  access (hit) to way last_access of set index; updates tree.
- fill  in  1  line fill into way last_access of set index; sets valid bit and updates tree.
- inval  in  1  clears valid bit of way last_access in set index; tree untouched.
- index  in  IDX_W  set being accessed or looked up.
- last_access  in  WAY_W  way operand for load, fill and inval.
- flush_req  in  1  start a full-array flush; sampled only when idle.
- plru  out  WAY_W  victim way for set index.
- valid_vec  out  WAYS  valid bits of set index.
- all_valid  out  1  &valid_vec.
- flush_busy  out  1  flush in progress; ops ignored.
- flush_done  out  1  one-cycle pulse at flush completion.

## Operation
- Per set: WAYS-1 tree bits in heap order: node 0 is the root, and node k has children 2k+1 and 2k+2. Leaves map to ways 0..WAYS-1, left to right.
- Bit = 0: the LRU lies in the left (lower-numbered) subtree. Bit = 1: the LRU lies in the right subtree.
- Touch (load or fill): every node on the path to way w is set to point away from w. A node gets 1 if w is in its left subtree, and 0 otherwise.
- Tree victim: walk from the root following the bits.
- plru = lowest-indexed way with valid_vec[way] = 0 if any exists; otherwise the tree victim.
- Simultaneous ops in the same cycle:
  - load and fill act as a single touch.
  - If inval and fill target the same way, inval wins for the valid bit; the touch still happens.
- Other sets are never modified by an operation.
- FSM states IDLE, FLUSH, DONE; counter fctr is IDX_W bits wide.
  - IDLE: if flush_req is high, go to FLUSH with fctr = 0. load, fill and inval in that same cycle are dropped.
  - FLUSH: each edge clears the tree bits and valid bits of set fctr, then increments fctr. When fctr == SETS-1 that set is cleared and the FSM goes to DONE. fctr wraps with no extra state.
  - DONE: flush_done = 1 for one cycle, then go to IDLE.
- flush_busy = (state != IDLE). While busy, load, fill, inval and flush_req are ignored. plru and valid_vec still reflect current stored state.

## Timing
- Reset values:
  - All tree bits 0 and all valid bits 0 in every set.
  - State IDLE, fctr 0.
  - Outputs: plru = 0, valid_vec = 0, all_valid = 0, flush_busy = 0, flush_done = 0.
- plru, valid_vec and all_valid are combinational from the registered state of set index, with no latency from index. An op at edge E is visible on these outputs after E. In the same cycle as the op they show the pre-update state.
- Flush latency: flush_req sampled at edge E0. flush_busy rises after E0. Set i is cleared at edge E0+1+i. DONE holds after edge E0+SETS, with flush_done high for that cycle. The FSM is IDLE after E0+SETS+1, giving SETS+1 busy cycles.
- flush_req held high continuously starts back-to-back flushes, with one IDLE cycle between them.
- rst mid-flush: at the next edge everything returns to reset values and flush_done is not pulsed.

## Test plan
- Reset, then sweep index 0..7 → plru = 0, valid_vec = 8'h00, all_valid = 0 for every set.
- fill set 3 with ways 0,1,…,7 on consecutive cycles → plru reads 0,1,…,7 before each fill. After the last fill: all_valid = 1 and plru = 0 (tree victim). Sets 2 and 4 remain at 8'h00.
- With set 3 full, load way 0 → plru = 4.
- Then inval way 6 in set 3 → next cycle plru = 6, valid_vec = 8'hBF, all_valid = 0. Same cycle fill+inval on way 6 → valid bit stays 0.
- Populate several sets, pulse flush_req:
  - flush_busy high for exactly 9 cycles; flush_done high only in the 9th.
  - fill and load issued while busy have no effect.
  - Afterwards every set shows plru = 0 and valid_vec = 0.
- Assert rst 3 cycles into a flush → next cycle flush_busy = 0, no flush_done pulse, all sets cleared. A following flush_req runs the full 9-cycle sequence.

Source files
------------

// File: rtl/plru_array.sv
// rtl/plru_array.sv - multi-set tree pseudo-LRU replacement array with sequenced flush
// Victim prefers the lowest invalid way; otherwise the per-set binary tree choice.
module plru_array #(
  parameter int WAYS = 8,
  parameter int SETS = 8,
  localparam int WAY_W = $clog2(WAYS),
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             fill,
  input  logic             inval,
  input  logic [IDX_W-1:0] index,
  input  logic [WAY_W-1:0] last_access,
  input  logic             flush_req,
  output logic [WAY_W-1:0] plru,
  output logic [WAYS-1:0]  valid_vec,
  output logic             all_valid,
  output logic             flush_busy,
  output logic             flush_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] fctr;
  logic [WAYS-2:0]  tree_q  [SETS];
  logic [WAYS-1:0]  valid_q [SETS];

  logic [WAYS-2:0]  cur_tree;
  logic [WAYS-2:0]  touched_tree;
  logic [WAYS-1:0]  cur_valid;
  logic [WAYS-1:0]  next_valid;
  logic             touch;
  logic             op_en;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;

  // Node index at level l is (2^l - 1) plus the top l bits of the way number.
  function automatic logic [WAY_W-1:0] tree_victim(input logic [WAYS-2:0] t);
    logic [WAYS-1:0]  tp;
    logic [WAY_W-1:0] way;
    logic [WAY_W-1:0] node;
    tp   = {1'b0, t};
    way  = '0;
    node = '0;
    for (int l = 0; l < WAY_W; l++) begin
      node = WAY_W'((1 << l) - 1) + way;
      way  = (way << 1) | WAY_W'(tp[node]);
    end
    return way;
  endfunction

  function automatic logic [WAYS-2:0] tree_touch(input logic [WAYS-2:0] t,
                                                 input logic [WAY_W-1:0] w);
    logic [WAYS-1:0]  tp;
    logic [WAY_W-1:0] prefix;
    logic [WAY_W-1:0] dir;
    logic [WAY_W-1:0] node;
    tp = {1'b0, t};
    for (int l = 0; l < WAY_W; l++) begin
      prefix   = w >> (WAY_W - l);
      dir      = w >> (WAY_W - 1 - l);
      node     = WAY_W'((1 << l) - 1) + prefix;
      tp[node] = ~dir[0];
    end
    return tp[WAYS-2:0];
  endfunction

  always_comb begin
    cur_tree  = tree_q[index];
    cur_valid = valid_q[index];
  end

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!cur_valid[i]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(i);
      end
    end
  end

  assign plru       = inv_found ? inv_way : tree_victim(cur_tree);
  assign valid_vec  = cur_valid;
  assign all_valid  = &cur_valid;
  assign flush_busy = (state != IDLE);
  assign flush_done = (state == DONE);

  // Inval is applied after fill so it wins on a same-way collision.
  always_comb begin
    touch        = load | fill;
    op_en        = (state == IDLE) && !flush_req;
    touched_tree = tree_touch(cur_tree, last_access);
    next_valid   = cur_valid;
    if (fill) next_valid[last_access] = 1'b1;
    if (inval) next_valid[last_access] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fctr  <= '0;
      for (int s = 0; s < SETS; s++) begin
        tree_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= FLUSH;
            fctr  <= '0;
          end else if (op_en) begin
            if (touch) tree_q[index] <= touched_tree;
            valid_q[index] <= next_valid;
          end
        end
        FLUSH: begin
          tree_q[fctr]  <= '0;
          valid_q[fctr] <= '0;
          fctr          <= fctr + 1'b1;
          if (fctr == IDX_W'(SETS - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plru_array.sv
// tb/tb_plru_array.sv - randomized self-checking bench for plru_array
// Reference keeps per-way last-touch timestamps; the tree victim avoids the most recent side.
module tb_plru_array;
  localparam int WAYS = 8;
  localparam int SETS = 8;

  logic       clk = 1'b0;
  logic       rst, load, fill, inval, flush_req;
  logic [2:0] index, last_access, plru;
  logic [7:0] valid_vec;
  logic       all_valid, flush_busy, flush_done;

  int n_pass = 0;
  int n_total = 0;
  int ts [SETS][WAYS];
  logic [WAYS-1:0] mv [SETS];
  int now = 0;
  int phase = 0;
  int obs_plru, obs_valid, obs_all, obs_busy, obs_done;
  int busy_n, done_n, done_at;

  plru_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst), .load(load), .fill(fill), .inval(inval),
    .index(index), .last_access(last_access), .flush_req(flush_req),
    .plru(plru), .valid_vec(valid_vec), .all_valid(all_valid),
    .flush_busy(flush_busy), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_clear_set(input int s);
    for (int w = 0; w < WAYS; w++) ts[s][w] = -1;
    mv[s] = '0;
  endtask

  function automatic int model_plru(input int s);
    int lo, hi, mid, ml, mr;
    for (int w = 0; w < WAYS; w++) if (!mv[s][w]) return w;
    lo = 0;
    hi = WAYS;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      ml = -1;
      mr = -1;
      for (int w = lo; w < mid; w++) if (ts[s][w] > ml) ml = ts[s][w];
      for (int w = mid; w < hi; w++) if (ts[s][w] > mr) mr = ts[s][w];
      if (ml > mr) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction

  task automatic model_edge();
    int s, w;
    s = int'(index);
    w = int'(last_access);
    if (rst) begin
      for (int i = 0; i < SETS; i++) model_clear_set(i);
      phase = 0;
    end else if (phase == 0) begin
      if (flush_req) phase = 1;
      else begin
        if (load || fill) begin
          now++;
          ts[s][w] = now;
        end
        if (fill) mv[s][w] = 1'b1;
        if (inval) mv[s][w] = 1'b0;
      end
    end else if (phase <= SETS) begin
      model_clear_set(phase - 1);
      phase++;
    end else begin
      phase = 0;
    end
  endtask

  task automatic run_cycle(input bit r, input bit l, input bit f, input bit iv,
                           input bit fr, input int idx, input int w);
    rst = r; load = l; fill = f; inval = iv; flush_req = fr;
    index = 3'(idx);
    last_access = 3'(w);
    #1;
    obs_plru = int'(plru);
    obs_valid = int'(valid_vec);
    obs_all = int'(all_valid);
    obs_busy = int'(flush_busy);
    obs_done = int'(flush_done);
    check("plru", obs_plru, model_plru(idx));
    check("valid_vec", obs_valid, int'(mv[idx]));
    check("all_valid", obs_all, int'(&mv[idx]));
    check("flush_busy", obs_busy, int'(phase != 0));
    check("flush_done", obs_done, int'(phase == SETS + 1));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic flush_window(input string tag);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 0; c < 9; c++) begin
      run_cycle(0, 1'($urandom_range(0, 1)), 1, 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), $urandom_range(0, 7));
      if (obs_busy != 0) busy_n++;
      if (obs_done != 0) begin done_n++; done_at = c; end
    end
    run_cycle(0, 0, 0, 0, 0, 0, 0);
    check({tag, "_busy_cycles"}, busy_n, 9);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_done_pos"}, done_at, 8);
    check({tag, "_idle_after"}, obs_busy, 0);
    for (int s = 0; s < SETS; s++) begin
      run_cycle(0, 0, 0, 0, 0, s, 0);
      check({tag, "_clr_valid"}, obs_valid, 0);
      check({tag, "_clr_plru"}, obs_plru, 0);
    end
  endtask

  initial begin
    rst = 1; load = 0; fill = 0; inval = 0; flush_req = 0; index = 0; last_access = 0;
    repeat (2) @(posedge clk);
    model_edge();
    #1;

    for (int s = 0; s < SETS; s++) begin
      run_cycle(0, 0, 0, 0, 0, s, 0);
      check("rst_plru", obs_plru, 0);
      check("rst_valid", obs_valid, 0);
      check("rst_all_valid", obs_all, 0);
    end

    for (int w = 0; w < WAYS; w++) begin
      run_cycle(0, 0, 1, 0, 0, 3, w);
      check("fill_seq_plru", obs_plru, w);
    end
    run_cycle(0, 0, 0, 0, 0, 3, 0);
    check("full_all_valid", obs_all, 1);
    check("full_plru", obs_plru, 0);
    run_cycle(0, 0, 0, 0, 0, 2, 0);
    check("set2_untouched", obs_valid, 0);
    run_cycle(0, 0, 0, 0, 0, 4, 0);
    check("set4_untouched", obs_valid, 0);

    run_cycle(0, 1, 0, 0, 0, 3, 0);
    run_cycle(0, 0, 0, 1, 0, 3, 6);
    check("load0_plru", obs_plru, 4);
    run_cycle(0, 0, 1, 1, 0, 3, 6);
    check("inval6_plru", obs_plru, 6);
    check("inval6_valid", obs_valid, 8'hBF);
    check("inval6_all_valid", obs_all, 0);
    run_cycle(0, 0, 0, 0, 0, 3, 0);
    check("fill_inval_valid", obs_valid, 8'hBF);

    for (int c = 0; c < 24; c++)
      run_cycle(0, 1'($urandom_range(0, 1)), 1, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7));
    run_cycle(0, 0, 0, 0, 1, 0, 0);
    flush_window("flush1");

    for (int c = 0; c < 12; c++)
      run_cycle(0, 0, 1, 0, 0, $urandom_range(0, 7), $urandom_range(0, 7));
    run_cycle(0, 0, 0, 0, 1, 0, 0);
    for (int c = 0; c < 3; c++) run_cycle(0, 0, 0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0);
    check("midrst_busy", obs_busy, 0);
    check("midrst_done", obs_done, 0);
    for (int s = 0; s < SETS; s++) begin
      run_cycle(0, 0, 0, 0, 0, s, 0);
      check("midrst_valid", obs_valid, 0);
    end
    run_cycle(0, 0, 0, 0, 1, 0, 0);
    flush_window("flush2");

    for (int c = 0; c < 600; c++)
      run_cycle(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 39) == 0), $urandom_range(0, 3), $urandom_range(0, 7));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
